// File: rtl/mem_ctrl_arbiter.sv
// Shares one main-memory request port between icache and dcache; icache has fixed priority.
// Define MEM_ARB_FAIRNESS_EN to let a starved dcache win after STARVE_LIMIT icache grants.
module mem_ctrl_arbiter #(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_aL,
    input  logic              icache_req_valid,
    input  logic [ADDR_W-1:0] icache_req_block_addr,
    output logic              icache_req_ready,
    output logic              icache_resp_valid,
    input  logic              dcache_req_valid,
    input  logic              dcache_req_type,
    input  logic [ADDR_W-1:0] dcache_req_block_addr,
    input  logic [DATA_W-1:0] dcache_req_block_data,
    output logic              dcache_req_ready,
    output logic              dcache_resp_valid,
    output logic [DATA_W-1:0] resp_block_data,
    output logic              mem_req_valid,
    output logic              mem_req_type,
    output logic [ADDR_W-1:0] mem_req_block_addr,
    output logic [DATA_W-1:0] mem_req_block_data,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_block_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              req_type_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;
    logic              req_valid_q;
    logic              grant_i;
    logic              grant_d;
    logic              resp_fire;
    logic              dcache_first;

    // The starve counter is 3 bits wide, so the limit must be reachable.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_limit_check
        $error("STARVE_LIMIT must be in 1..7");
    end

`ifdef MEM_ARB_FAIRNESS_EN
    logic [2:0] starve_cnt;

    assign dcache_first = (starve_cnt == 3'(STARVE_LIMIT)) && icache_req_valid && dcache_req_valid;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            starve_cnt <= 3'd0;
        end else if (state == IDLE) begin
            if (grant_d || !dcache_req_valid) begin
                starve_cnt <= 3'd0;
            end else if (grant_i && starve_cnt != 3'd7) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end
`else
    assign dcache_first = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants and responses are combinational so a requester sees ready in its own valid cycle.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        resp_fire = 1'b0;
        case (state)
            IDLE: begin
                if (rst_aL) begin
                    grant_i = icache_req_valid && !dcache_first;
                    grant_d = dcache_req_valid && (!icache_req_valid || dcache_first);
                end
                if (grant_i || grant_d) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_nxt = req_type_q ? IDLE : RESP;
                end
            end
            RESP: begin
                resp_fire = mem_resp_valid;
                if (mem_resp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            owner       <= 1'b0;
            req_type_q  <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_valid_q <= 1'b0;
        end else begin
            if (grant_i) begin
                owner       <= 1'b0;
                req_type_q  <= 1'b0;
                req_addr_q  <= icache_req_block_addr;
                req_data_q  <= '0;
                req_valid_q <= 1'b1;
            end else if (grant_d) begin
                owner       <= 1'b1;
                req_type_q  <= dcache_req_type;
                req_addr_q  <= dcache_req_block_addr;
                req_data_q  <= dcache_req_block_data;
                req_valid_q <= 1'b1;
            end else if (req_valid_q && mem_req_ready) begin
                req_valid_q <= 1'b0;
            end
        end
    end

    assign icache_req_ready   = grant_i;
    assign dcache_req_ready   = grant_d;
    assign icache_resp_valid  = resp_fire && !owner;
    assign dcache_resp_valid  = resp_fire && owner;
    assign resp_block_data    = resp_fire ? mem_resp_block_data : '0;
    assign mem_req_valid      = req_valid_q;
    assign mem_req_type       = req_type_q;
    assign mem_req_block_addr = req_addr_q;
    assign mem_req_block_data = req_data_q;

endmodule
